mem_copy_engine: RTL and testbench
==================================

# mem_copy_engine

DMA-style initiator on the `memory_bus` `CONSUMER` modport. It copies or fills a run of elements between memory regions (ROM/RAM/FB/IO) without the CPU. Typical uses are ROM→RAM asset loads and frame-buffer clears. It sits beside the CPU load/store path; a top-level arbiter selects which consumer drives `memory_bus`. The engine obeys the bus dispatch/busy handshake exactly as the CPU does.

## Interface
Parameters:
- `LEN_WIDTH`, default 16: width of the element-count port.

Ports:
- `clk_in`  input  1: system clock; all logic is on its rising edge.
- `rst_in`  input  1: reset, asynchronous and active-low.
- `start_in`  input  1: one-cycle request. Sampled only in IDLE; ignored otherwise.
- `mode_in`  input  1: 0 = COPY (read src, write dst), 1 = FILL (write `fill_data_in` to dst).
- `width_in`  input  `mem::mem_width_t`: element width. BYTE gives stride 1, WORD stride 2, DWORD stride 4.
- `src_addr_in`  input  32: first source address (COPY only).
- `dst_addr_in`  input  32: first destination address.
- `len_in`  input  LEN_WIDTH: element count.
- `fill_data_in`  input  32: FILL pattern.
- `abort_in`  input  1: stop after the in-flight bus transaction completes.
- `busy_out`  output  1: job in progress.
- `done_out`  output  1: one-cycle completion pulse.
- `error_out`  output  1: sticky flag for the last job; cleared on the next accepted start.
- `bus`  `memory_bus.CONSUMER`: drives addr, write_data, dispatch_read, dispatch_write, mem_width.

## Operation
- States: IDLE, ISSUE_RD, WAIT_RD, ISSUE_WR, WAIT_WR, DONE.
- IDLE:
  - When `start_in` is high, latch all job inputs, clear `error_out`, and compute the dst region via `mmio_mappings`.
  - If dst region is ROM or UNKNOWN: set `error_out` and go to DONE. No bus traffic.
  - If `len_in`==0: go to DONE. No bus traffic.
  - Otherwise go to ISSUE_RD (COPY) or ISSUE_WR (FILL).
- ISSUE_RD: drive `bus.dispatch_read`=1 and `bus.addr`=src, for exactly one cycle. Then go to WAIT_RD.
- WAIT_RD: hold until `bus.busy`==0. In that cycle, capture `bus.read_data` into the data register, then go to ISSUE_WR.
- ISSUE_WR: drive `bus.dispatch_write`=1, `bus.addr`=dst, `bus.write_data`=data register (FILL: pattern), for one cycle. Then go to WAIT_WR.
- WAIT_WR: hold until `bus.busy`==0. Then:
  - src += stride (COPY), dst += stride, remaining -= 1.
  - If remaining==0 or abort is pending: go to DONE.
  - Else: go to ISSUE_RD (COPY) or ISSUE_WR (FILL).
- DONE: `done_out`=1 for one cycle, then IDLE.
- `abort_in`:
  - Latched into a pending flag in any non-IDLE state.
  - Never cuts a transaction mid-way; honoured only at the WAIT_WR exit.
  - An aborted job sets `error_out`.
- Bus rules:
  - `dispatch_read` and `dispatch_write` are never both high.
  - Each is high only in its ISSUE state.
  - `bus.mem_width` equals the latched width throughout the job.
  - `addr` and `write_data` are held stable from ISSUE through WAIT.
- Arithmetic:
  - Addresses are 32-bit and wrap modulo 2^32; no region-crossing check.
  - The remaining count is LEN_WIDTH bits and never underflows.
- Unused upper read_data bits for BYTE/WORD are zero as delivered by the bus. They are passed through unmodified.

## Timing
- Reset values: state IDLE; `busy_out` 0, `done_out` 0, `error_out` 0; both dispatches 0; `addr`, `write_data` 0; `mem_width` BYTE; abort-pending 0.
- Reset asserted mid-job returns to IDLE immediately with no `done_out`. The responder is reset with the same signal.
- `busy_out` is registered. It is high from the cycle after start acceptance through the DONE cycle.
- Bus latency: a transaction is the dispatch cycle plus L cycles of `busy` high. The first cycle with `busy` low is the WAIT exit cycle.
- Per-element cost:
  - COPY: (2+L_rd)+(2+L_wr) cycles.
  - FILL: 2+L_wr cycles.
- Job latency: from start accepted at cycle 0, `done_out` rises at 1 + N·element_cost (+0 extra for a zero-length or error job, i.e. cycle 1).
- `start_in` during a job is dropped, not queued.

## Structure
- Package `dma`: `dma_state_t` enum and `dma_mode_t` (COPY, FILL). Stride lookup is a function of `mem::mem_width_t` living in `dma`.
- Reuse `mmio_mappings` for the dst region check. No other sub-module; a single FSM plus address/count datapath.

## Test plan
- COPY BYTE from ROM 0x0000_0010 to RAM 0x0001_0100, len 4, responder L=3 → 4 reads then 4 writes, interleaved read/write, addresses +1. `done_out` at cycle 41. RAM holds the ROM bytes.
- FILL WORD 0x0000_F800 to FB 0x0002_0000, len 3, L=3 → writes at 0x0002_0000/2/4, each `write_data`=0xF800. `done_out` at cycle 16. No `dispatch_read` ever.
- len 0, or dst 0x0000_0040 (ROM) → no dispatches, `done_out` at cycle 1. `error_out`=0 for len 0, `error_out`=1 for ROM dst.
- Assert `abort_in` during the second read of a len-8 COPY → second write still issues, then DONE. `error_out`=1, dst advanced by exactly 2 elements.
- `start_in` pulsed mid-job → ignored. Reset pulsed in WAIT_RD → all outputs return to reset values with no `done_out`. The next start runs normally.
- Handshake checker throughout: each dispatch is one cycle, issued only when `bus.busy` was low the previous cycle; `addr` and `write_data` stable until `busy` falls.

Source files
------------

// File: rtl/dma.sv
// Copy-engine FSM states, job modes and the element stride lookup.
package dma;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_RD = 3'd1,
        WAIT_RD  = 3'd2,
        ISSUE_WR = 3'd3,
        WAIT_WR  = 3'd4,
        DONE     = 3'd5
    } dma_state_t;

    typedef enum logic {
        COPY = 1'b0,
        FILL = 1'b1
    } dma_mode_t;

    // Address increment between consecutive elements of a job.
    function automatic logic [31:0] elem_stride(input mem::mem_width_t w);
        case (w)
            mem::BYTE:  elem_stride = 32'd1;
            mem::WORD:  elem_stride = 32'd2;
            mem::DWORD: elem_stride = 32'd4;
            default:    elem_stride = 32'd1;
        endcase
    endfunction

endpackage

// File: rtl/mem.sv
// Memory-system types shared by every bus consumer: access widths, regions and the address map.
package mem;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        WORD  = 2'd1,
        DWORD = 2'd2
    } mem_width_t;

    typedef enum logic [2:0] {
        REGION_ROM     = 3'd0,
        REGION_RAM     = 3'd1,
        REGION_FB      = 3'd2,
        REGION_IO      = 3'd3,
        REGION_UNKNOWN = 3'd4
    } mem_region_t;

    // Region boundaries: each region is 64 KiB, ROM starts at address zero.
    localparam logic [31:0] RAM_BASE = 32'h0001_0000;
    localparam logic [31:0] FB_BASE  = 32'h0002_0000;
    localparam logic [31:0] IO_BASE  = 32'h0003_0000;
    localparam logic [31:0] IO_END   = 32'h0004_0000;

endpackage

// File: rtl/memory_bus.sv
// Shared memory bus: one consumer issues dispatches, the provider answers with busy/read_data.
interface memory_bus;

    logic [31:0]         addr;
    logic [31:0]         write_data;
    logic [31:0]         read_data;
    logic                dispatch_read;
    logic                dispatch_write;
    logic                busy;
    mem::mem_width_t     mem_width;

    modport CONSUMER (
        output addr,
        output write_data,
        output dispatch_read,
        output dispatch_write,
        output mem_width,
        input  read_data,
        input  busy
    );

    modport PROVIDER (
        input  addr,
        input  write_data,
        input  dispatch_read,
        input  dispatch_write,
        input  mem_width,
        output read_data,
        output busy
    );

endinterface

// File: rtl/mmio_mappings.sv
// Combinational address decoder mapping a byte address onto its memory region.
module mmio_mappings
    import mem::*;
(
    input  logic [31:0] addr,
    output mem_region_t region
);

    // Regions are contiguous, so an ordered compare chain is enough.
    always_comb begin
        region = REGION_UNKNOWN;
        if (addr < RAM_BASE) begin
            region = REGION_ROM;
        end else if (addr < FB_BASE) begin
            region = REGION_RAM;
        end else if (addr < IO_BASE) begin
            region = REGION_FB;
        end else if (addr < IO_END) begin
            region = REGION_IO;
        end
    end

endmodule

// File: rtl/mem_copy_engine.sv
// DMA-style copy/fill engine driving the memory bus one element at a time.
module mem_copy_engine
    import mem::*;
    import dma::*;
#(
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic                 mode_in,
    input  mem_width_t           width_in,
    input  logic [31:0]          src_addr_in,
    input  logic [31:0]          dst_addr_in,
    input  logic [LEN_WIDTH-1:0] len_in,
    input  logic [31:0]          fill_data_in,
    input  logic                 abort_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 error_out,
    memory_bus.CONSUMER          bus
);

    dma_state_t           state_q;
    dma_mode_t            mode_q;
    logic [31:0]          src_q;
    logic [31:0]          dst_q;
    logic [LEN_WIDTH-1:0] remaining_q;
    logic [31:0]          fill_q;
    logic                 abort_pend_q;

    mem_region_t          dst_region_c;
    logic                 dst_bad_c;
    logic [31:0]          stride_c;
    logic [31:0]          src_next_c;
    logic [31:0]          dst_next_c;
    logic                 abort_hit_c;

    // Destination must be writable; checked on the raw start inputs.
    mmio_mappings u_dst_map (
        .addr   (dst_addr_in),
        .region (dst_region_c)
    );

    // Element stride and next addresses; 32-bit adds wrap naturally.
    always_comb begin
        dst_bad_c   = (dst_region_c == REGION_ROM) || (dst_region_c == REGION_UNKNOWN);
        stride_c    = elem_stride(bus.mem_width);
        src_next_c  = src_q + stride_c;
        dst_next_c  = dst_q + stride_c;
        abort_hit_c = abort_pend_q | abort_in;
    end

    // Job FSM with registered bus and status outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q            <= IDLE;
            mode_q             <= COPY;
            src_q              <= '0;
            dst_q              <= '0;
            remaining_q        <= '0;
            fill_q             <= '0;
            abort_pend_q       <= 1'b0;
            busy_out           <= 1'b0;
            done_out           <= 1'b0;
            error_out          <= 1'b0;
            bus.addr           <= '0;
            bus.write_data     <= '0;
            bus.dispatch_read  <= 1'b0;
            bus.dispatch_write <= 1'b0;
            bus.mem_width      <= BYTE;
        end else begin
            // Abort is remembered until the current element's write completes.
            if (state_q != IDLE && abort_in) begin
                abort_pend_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        mode_q        <= dma_mode_t'(mode_in);
                        src_q         <= src_addr_in;
                        dst_q         <= dst_addr_in;
                        remaining_q   <= len_in;
                        fill_q        <= fill_data_in;
                        bus.mem_width <= width_in;
                        abort_pend_q  <= 1'b0;
                        error_out     <= 1'b0;
                        busy_out      <= 1'b1;
                        if (dst_bad_c) begin
                            error_out <= 1'b1;
                            done_out  <= 1'b1;
                            state_q   <= DONE;
                        end else if (len_in == '0) begin
                            done_out  <= 1'b1;
                            state_q   <= DONE;
                        end else if (dma_mode_t'(mode_in) == FILL) begin
                            bus.dispatch_write <= 1'b1;
                            bus.addr           <= dst_addr_in;
                            bus.write_data     <= fill_data_in;
                            state_q            <= ISSUE_WR;
                        end else begin
                            bus.dispatch_read  <= 1'b1;
                            bus.addr           <= src_addr_in;
                            state_q            <= ISSUE_RD;
                        end
                    end
                end

                ISSUE_RD: begin
                    bus.dispatch_read <= 1'b0;
                    state_q           <= WAIT_RD;
                end

                WAIT_RD: begin
                    if (!bus.busy) begin
                        // write_data doubles as the element data register.
                        bus.write_data     <= bus.read_data;
                        bus.addr           <= dst_q;
                        bus.dispatch_write <= 1'b1;
                        state_q            <= ISSUE_WR;
                    end
                end

                ISSUE_WR: begin
                    bus.dispatch_write <= 1'b0;
                    state_q            <= WAIT_WR;
                end

                WAIT_WR: begin
                    if (!bus.busy) begin
                        src_q       <= src_next_c;
                        dst_q       <= dst_next_c;
                        remaining_q <= remaining_q - LEN_WIDTH'(1);
                        if (remaining_q == LEN_WIDTH'(1) || abort_hit_c) begin
                            if (abort_hit_c) begin
                                error_out <= 1'b1;
                            end
                            done_out <= 1'b1;
                            state_q  <= DONE;
                        end else if (mode_q == FILL) begin
                            bus.dispatch_write <= 1'b1;
                            bus.addr           <= dst_next_c;
                            bus.write_data     <= fill_q;
                            state_q            <= ISSUE_WR;
                        end else begin
                            bus.dispatch_read  <= 1'b1;
                            bus.addr           <= src_next_c;
                            state_q            <= ISSUE_RD;
                        end
                    end
                end

                DONE: begin
                    done_out <= 1'b0;
                    busy_out <= 1'b0;
                    state_q  <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench: byte-memory responder, bus monitor and an element-level job model.
module tb_mem_copy_engine;
    import mem::*;

    localparam int unsigned LEN_WIDTH = 16;
    localparam int unsigned MEM_BYTES = 262144;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 mode;
    mem_width_t           width;
    logic [31:0]          src;
    logic [31:0]          dst;
    logic [LEN_WIDTH-1:0] len;
    logic [31:0]          fill;
    logic                 abort;
    logic                 busy_out;
    logic                 done_out;
    logic                 error_out;

    memory_bus bus_if ();

    mem_copy_engine #(.LEN_WIDTH(LEN_WIDTH)) dut (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .start_in     (start),
        .mode_in      (mode),
        .width_in     (width),
        .src_addr_in  (src),
        .dst_addr_in  (dst),
        .len_in       (len),
        .fill_data_in (fill),
        .abort_in     (abort),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .error_out    (error_out),
        .bus          (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem_arr   [MEM_BYTES];
    logic [7:0] model_mem [MEM_BYTES];

    function automatic int unsigned nbytes(input mem_width_t w);
        case (w)
            BYTE:    return 1;
            WORD:    return 2;
            default: return 4;
        endcase
    endfunction

    // Responder: memory access happens at the dispatch edge, then busy for L cycles.
    int unsigned lat_rd = 0;
    int unsigned lat_wr = 0;
    int unsigned busy_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_if.busy      <= 1'b0;
            bus_if.read_data <= '0;
            busy_cnt         <= 0;
        end else if (bus_if.dispatch_read) begin
            logic [31:0] v;
            v = '0;
            for (int b = 0; b < int'(nbytes(bus_if.mem_width)); b++)
                v[8*b +: 8] = mem_arr[18'(bus_if.addr + 32'(b))];
            bus_if.read_data <= v;
            busy_cnt         <= lat_rd;
            bus_if.busy      <= (lat_rd != 0);
        end else if (bus_if.dispatch_write) begin
            for (int b = 0; b < int'(nbytes(bus_if.mem_width)); b++)
                mem_arr[18'(bus_if.addr + 32'(b))] = bus_if.write_data[8*b +: 8];
            busy_cnt    <= lat_wr;
            bus_if.busy <= (lat_wr != 0);
        end else if (busy_cnt != 0) begin
            busy_cnt    <= busy_cnt - 1;
            bus_if.busy <= (busy_cnt > 1);
        end
    end

    // Monitor: records dispatches and done pulses, counts handshake violations.
    logic [31:0] rd_q[$];
    logic [63:0] wr_q[$];
    int          viol = 0;
    int          done_cnt = 0;
    bit          done_seen = 0;
    bit          done_busy = 0;
    int unsigned done_cyc = 0;
    mem_width_t  exp_w = BYTE;
    bit          prev_busy, prev_dr, prev_dw, hold;
    logic [31:0] hold_addr, hold_wd;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 0; prev_dr = 0; prev_dw = 0; hold = 0;
        end else begin
            if (bus_if.dispatch_read && bus_if.dispatch_write) viol++;
            if ((bus_if.dispatch_read || bus_if.dispatch_write) && prev_busy) viol++;
            if ((bus_if.dispatch_read && prev_dr) || (bus_if.dispatch_write && prev_dw)) viol++;
            if ((bus_if.dispatch_read || bus_if.dispatch_write) && bus_if.mem_width !== exp_w) viol++;
            if (hold && (bus_if.addr !== hold_addr || bus_if.write_data !== hold_wd)) viol++;
            if (bus_if.dispatch_read || bus_if.dispatch_write) begin
                hold = 1; hold_addr = bus_if.addr; hold_wd = bus_if.write_data;
            end else if (!bus_if.busy) begin
                hold = 0;
            end
            if (bus_if.dispatch_read) rd_q.push_back(bus_if.addr);
            if (bus_if.dispatch_write) wr_q.push_back({bus_if.addr, bus_if.write_data});
            if (done_out) begin
                done_cnt++;
                if (!done_seen) begin
                    done_seen = 1; done_cyc = cyc; done_busy = busy_out;
                end
            end
            prev_busy = bus_if.busy;
            prev_dr   = bus_if.dispatch_read;
            prev_dw   = bus_if.dispatch_write;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "/ctrl"}, 64'({busy_out, done_out, error_out, bus_if.dispatch_read,
                                 bus_if.dispatch_write, bus_if.mem_width}), 64'(0));
        chk({tag, "/addr_data"}, {bus_if.addr, bus_if.write_data}, 64'(0));
    endtask

    // Runs one job: model predicts element transfers, latency and error, then compares.
    task automatic run_job(input string tag, input logic m, input mem_width_t w,
                           input logic [31:0] s, input logic [31:0] d, input int unsigned n,
                           input logic [31:0] f, input int unsigned lr, input int unsigned lw,
                           input int unsigned abort_at, input bit poke);
        int unsigned st, cost, n_eff, exp_done, bad, start_cyc;
        bit          dst_ok, exp_err;
        logic [31:0] er[$];
        logic [63:0] ew[$];
        logic [31:0] v, ra, wa;

        st     = nbytes(w);
        cost   = m ? 2 + lw : 4 + lr + lw;
        dst_ok = (d >= 32'h0001_0000) && (d < 32'h0004_0000);
        n_eff  = dst_ok ? n : 0;
        if (dst_ok && abort_at != 0 && abort_at <= n * cost) begin
            n_eff = (abort_at - 1) / cost + 1;
            if (n_eff > n) n_eff = n;
        end
        exp_err  = !dst_ok || (n != 0 && abort_at != 0 && abort_at <= n * cost);
        exp_done = (n_eff == 0) ? 1 : 1 + n_eff * cost;

        for (int unsigned i = 0; i < n_eff; i++) begin
            ra = s + 32'(i * st);
            wa = d + 32'(i * st);
            if (m) begin
                v = f;
            end else begin
                v = '0;
                for (int b = 0; b < int'(st); b++) v[8*b +: 8] = model_mem[18'(ra + 32'(b))];
                er.push_back(ra);
            end
            for (int b = 0; b < int'(st); b++) model_mem[18'(wa + 32'(b))] = v[8*b +: 8];
            ew.push_back({wa, v});
        end

        @(posedge clk); #1;
        rd_q.delete(); wr_q.delete();
        viol = 0; done_cnt = 0; done_seen = 0;
        lat_rd = lr; lat_wr = lw; exp_w = w;
        mode = m; width = w; src = s; dst = d; len = LEN_WIDTH'(n); fill = f;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int unsigned c = 1; c < exp_done + 40 && !done_seen; c++) begin
            abort = (c == abort_at);
            if (poke && c == 3) begin
                start = 1'b1; mode = ~m; dst = 32'h0000_0040; len = '1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0; start = 1'b0;

        chk({tag, "/done_seen"}, 64'(done_seen), 64'(1));
        chk({tag, "/latency"}, 64'(done_cyc - start_cyc), 64'(exp_done));
        chk({tag, "/done_pulses"}, 64'(done_cnt), 64'(1));
        chk({tag, "/busy_in_done"}, 64'(done_busy), 64'(1));
        @(negedge clk);
        chk({tag, "/error"}, 64'(error_out), 64'(exp_err));
        chk({tag, "/idle_after"}, 64'({busy_out, done_out}), 64'(0));
        chk({tag, "/reads"}, 64'(rd_q.size()), 64'(er.size()));
        for (int i = 0; i < rd_q.size() && i < er.size(); i++)
            chk({tag, $sformatf("/rd%0d", i)}, 64'(rd_q[i]), 64'(er[i]));
        chk({tag, "/writes"}, 64'(wr_q.size()), 64'(ew.size()));
        for (int i = 0; i < wr_q.size() && i < ew.size(); i++)
            chk({tag, $sformatf("/wr%0d", i)}, wr_q[i], ew[i]);
        chk({tag, "/handshake"}, 64'(viol), 64'(0));
        bad = 0;
        for (int i = 0; i < int'(MEM_BYTES); i++)
            if (mem_arr[i] !== model_mem[i]) bad++;
        chk({tag, "/mem_bytes_differ"}, 64'(bad), 64'(0));
    endtask

    initial begin
        mem_width_t  rw;
        int unsigned rst_done;
        logic        rm;
        int unsigned rn, rl, rwl, rst_st, rab;
        logic [31:0] rs, rd;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; width = BYTE; src = '0; dst = '0;
        len = '0; fill = '0; abort = 1'b0;
        for (int i = 0; i < int'(MEM_BYTES); i++) begin
            mem_arr[i]   = 8'($urandom);
            model_mem[i] = mem_arr[i];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_job("copy_byte",  1'b0, BYTE,  32'h0000_0010, 32'h0001_0100, 4, 32'h0, 3, 3, 0, 1'b0);
        run_job("fill_word",  1'b1, WORD,  32'h0,         32'h0002_0000, 3, 32'h0000_F800, 3, 3, 0, 1'b0);
        run_job("len_zero",   1'b0, DWORD, 32'h0000_0020, 32'h0001_0400, 0, 32'h0, 2, 2, 0, 1'b0);
        run_job("rom_dst",    1'b1, BYTE,  32'h0,         32'h0000_0040, 5, 32'hAA, 2, 2, 0, 1'b0);
        run_job("abort",      1'b0, BYTE,  32'h0000_0100, 32'h0001_0200, 8, 32'h0, 3, 3, 12, 1'b0);
        run_job("start_poke", 1'b1, DWORD, 32'h0,         32'h0003_0000, 4, 32'hDEAD_BEEF, 1, 2, 0, 1'b1);
        run_job("dword_l0",   1'b0, DWORD, 32'h0000_0200, 32'h0001_0800, 3, 32'h0, 0, 0, 0, 1'b0);

        // Reset while the first read is outstanding: no done, outputs back to reset values.
        @(posedge clk); #1;
        done_cnt = 0; lat_rd = 3; lat_wr = 3;
        mode = 1'b0; width = WORD; src = 32'h0000_0300; dst = 32'h0001_0A00; len = 16'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_state("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_done = done_cnt;
        chk("mid_reset/no_done", 64'(rst_done), 64'(0));
        chk("mid_reset/idle", 64'({busy_out, bus_if.dispatch_read, bus_if.dispatch_write}), 64'(0));

        run_job("after_reset", 1'b0, WORD, 32'h0000_0300, 32'h0001_0A00, 4, 32'h0, 2, 1, 0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            rm     = 1'($urandom_range(0, 1));
            rw     = mem_width_t'($urandom_range(0, 2));
            rst_st = nbytes(rw);
            rn     = $urandom_range(1, 6);
            rl     = $urandom_range(0, 4);
            rwl    = $urandom_range(0, 4);
            rs     = 32'($urandom_range(0, 32'hFE00)) & ~(rst_st - 1);
            rd     = 32'h0001_0000 * 32'($urandom_range(1, 3)) +
                     (32'($urandom_range(0, 32'hF000)) & ~(rst_st - 1));
            rab    = 0;
            if ($urandom_range(0, 3) == 0)
                rab = $urandom_range(1, rn * (rm ? 2 + rwl : 4 + rl + rwl));
            run_job($sformatf("rand%0d", k), rm, rw, rs, rd, rn, $urandom, rl, rwl, rab, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
